// File: rtl/vslide_pkg.sv
// Shared types and helpers for the vector slide engine.
package vslide_pkg;

    localparam int ELEN = 32;

    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;

    typedef enum logic [1:0] {
        SLIDE_UP    = 2'd0,
        SLIDE_DOWN  = 2'd1,
        SLIDE1_UP   = 2'd2,
        SLIDE1_DOWN = 2'd3
    } vslide_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } vslide_state_e;

    // SEW codes 2 and 3 both mean 32-bit elements.
    function automatic int elem_count(input logic [1:0] sew, input int vlen);
        case (sew)
            SEW_8:   return vlen / 8;
            SEW_16:  return vlen / 16;
            default: return vlen / 32;
        endcase
    endfunction

endpackage

// File: rtl/vslide_unit_if.sv
// Request/response handshake bundle between a requester and vslide_unit.
interface vslide_unit_if
    import vslide_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int N_MAX = VLEN / 8,
    parameter int OFF_W = $clog2(N_MAX) + 1
);
    logic             in_valid;
    logic             in_ready;
    vslide_op_e       op;
    logic [1:0]       sew;
    logic [OFF_W-1:0] offset;
    logic [VLEN-1:0]  src;
    logic [VLEN-1:0]  dst_old;
    logic [ELEN-1:0]  fill;
    logic             out_valid;
    logic             out_ready;
    logic [VLEN-1:0]  result;
    logic             busy;

    modport master (
        output in_valid, op, sew, offset, src, dst_old, fill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, sew, offset, src, dst_old, fill, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/vslide_elem_sel.sv
// Picks the element that belongs at result position idx for the latched slide request.
module vslide_elem_sel
    import vslide_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int N_MAX = VLEN / 8,
    parameter int OFF_W = $clog2(N_MAX) + 1
) (
    input  vslide_op_e       i_op,
    input  logic [1:0]       i_sew,
    input  logic [OFF_W-1:0] i_off,
    input  logic [OFF_W-1:0] i_idx,
    input  logic [VLEN-1:0]  i_src,
    input  logic [VLEN-1:0]  i_dst_old,
    input  logic [ELEN-1:0]  i_fill,
    output logic [ELEN-1:0]  o_elem
);
    localparam int LOG8 = $clog2(N_MAX);

    // Callers only pass indices already known to be below the element count.
    function automatic logic [ELEN-1:0] pick(input logic [VLEN-1:0] v,
                                             input logic [1:0] s,
                                             input logic [OFF_W:0] k);
        logic [N_MAX-1:0][7:0]    b;
        logic [N_MAX/2-1:0][15:0] h;
        logic [N_MAX/4-1:0][31:0] w;
        b = v;
        h = v;
        w = v;
        case (s)
            SEW_8:   return {24'b0, b[k[LOG8-1:0]]};
            SEW_16:  return {16'b0, h[k[LOG8-2:0]]};
            default: return w[k[LOG8-3:0]];
        endcase
    endfunction

    function automatic logic [ELEN-1:0] trunc(input logic [ELEN-1:0] v, input logic [1:0] s);
        case (s)
            SEW_8:   return {24'b0, v[7:0]};
            SEW_16:  return {16'b0, v[15:0]};
            default: return v;
        endcase
    endfunction

    logic [OFF_W:0] w_n;
    logic [OFF_W:0] w_idx;
    logic [OFF_W:0] w_eoff;
    logic [OFF_W:0] w_dn;

    always_comb begin
        w_n    = (OFF_W+1)'(elem_count(i_sew, VLEN));
        w_idx  = {1'b0, i_idx};
        w_eoff = (i_op == SLIDE1_UP || i_op == SLIDE1_DOWN) ? (OFF_W+1)'(1) : {1'b0, i_off};
        w_dn   = w_idx + w_eoff;
        o_elem = '0;
        if (i_op == SLIDE_UP || i_op == SLIDE1_UP) begin
            if (w_idx < w_eoff)
                o_elem = (i_op == SLIDE1_UP) ? trunc(i_fill, i_sew) : pick(i_dst_old, i_sew, w_idx);
            else
                o_elem = pick(i_src, i_sew, w_idx - w_eoff);
        end else begin
            if (w_dn < w_n)
                o_elem = pick(i_src, i_sew, w_dn);
            else if (i_op == SLIDE1_DOWN)
                o_elem = trunc(i_fill, i_sew);
        end
    end
endmodule

// File: rtl/vslide_unit.sv
// Vector slide engine: accepts one request, writes one result element per cycle, then
// holds the slid register until the consumer takes it.
module vslide_unit
    import vslide_pkg::*;
#(
    parameter int VLEN  = 128,
    parameter int N_MAX = VLEN / 8,
    parameter int OFF_W = $clog2(N_MAX) + 1
) (
    input  logic         clk,
    input  logic         rst,
    vslide_unit_if.slave bus
);
    localparam int LOG8 = $clog2(N_MAX);

    vslide_state_e    r_state;
    vslide_op_e       r_op;
    logic [1:0]       r_sew;
    logic [OFF_W-1:0] r_off;
    logic [OFF_W-1:0] r_idx;
    logic [OFF_W-1:0] r_n;
    logic [VLEN-1:0]  r_src;
    logic [VLEN-1:0]  r_dst;
    logic [ELEN-1:0]  r_fill;
    logic [VLEN-1:0]  r_result;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [ELEN-1:0]  w_elem;

    vslide_elem_sel #(.VLEN(VLEN), .N_MAX(N_MAX), .OFF_W(OFF_W)) u_sel (
        .i_op      (r_op),
        .i_sew     (r_sew),
        .i_off     (r_off),
        .i_idx     (r_idx),
        .i_src     (r_src),
        .i_dst_old (r_dst),
        .i_fill    (r_fill),
        .o_elem    (w_elem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= SLIDE_UP;
            r_sew       <= '0;
            r_off       <= '0;
            r_idx       <= '0;
            r_n         <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_fill      <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= bus.op;
                        r_sew      <= bus.sew;
                        r_off      <= bus.offset;
                        r_src      <= bus.src;
                        r_dst      <= bus.dst_old;
                        r_fill     <= bus.fill;
                        r_n        <= OFF_W'(elem_count(bus.sew, VLEN));
                        r_result   <= '0;
                        r_idx      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    case (r_sew)
                        SEW_8:   r_result[8*int'(r_idx[LOG8-1:0]) +: 8]   <= w_elem[7:0];
                        SEW_16:  r_result[16*int'(r_idx[LOG8-2:0]) +: 16] <= w_elem[15:0];
                        default: r_result[32*int'(r_idx[LOG8-3:0]) +: 32] <= w_elem;
                    endcase
                    r_idx <= r_idx + OFF_W'(1);
                    if (r_idx == r_n - OFF_W'(1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_vslide_unit.sv
// Self-checking bench for vslide_unit: directed table, random vectors vs a reference model,
// plus backpressure and mid-run reset sequences.
module tb_vslide_unit;
    import vslide_pkg::*;

    localparam int VLEN = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vslide_unit_if #(.VLEN(VLEN)) bus ();
    vslide_unit #(.VLEN(VLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [1:0]   sew;
        logic [4:0]   off;
        logic [127:0] src;
        logic [127:0] dst;
        logic [31:0]  fill;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Reference: element-by-element from the slide rules, using shifts over the whole register.
    function automatic logic [127:0] model(input int op, input int sew, input int off,
                                           input logic [127:0] src, input logic [127:0] dst,
                                           input logic [31:0] fill);
        int w, n, eo;
        logic [127:0] m, r, e;
        w  = (sew == 0) ? 8 : (sew == 1) ? 16 : 32;
        n  = 128 / w;
        eo = (op >= 2) ? 1 : off;
        m  = (128'd1 << w) - 128'd1;
        r  = '0;
        for (int i = 0; i < n; i++) begin
            case (op)
                0:       e = (i < eo) ? (dst >> (i*w)) : (src >> ((i-eo)*w));
                1:       e = (i + eo < n) ? (src >> ((i+eo)*w)) : 128'd0;
                2:       e = (i == 0) ? {96'd0, fill} : (src >> ((i-1)*w));
                default: e = (i == n-1) ? {96'd0, fill} : (src >> ((i+1)*w));
            endcase
            r = r | ((e & m) << (i*w));
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called #1 after an edge with the unit idle; returns #1 after the accept edge.
    task automatic start_req(input logic [1:0] op, input logic [1:0] sew, input logic [4:0] off,
                             input logic [127:0] src, input logic [127:0] dst, input logic [31:0] fill);
        bus.op       = vslide_op_e'(op);
        bus.sew      = sew;
        bus.offset   = off;
        bus.src      = src;
        bus.dst_old  = dst;
        bus.fill     = fill;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = vslide_op_e'(2'($urandom));
        bus.sew      = 2'($urandom);
        bus.offset   = 5'($urandom);
        bus.src      = rnd128();
        bus.dst_old  = rnd128();
        bus.fill     = $urandom;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [1:0] sew,
                           input logic [4:0] off, input logic [127:0] src, input logic [127:0] dst,
                           input logic [31:0] fill, input logic [127:0] exp, input int exp_lat);
        int lat;
        chk({name, "_in_ready"}, bus.in_ready, 1);
        start_req(op, sew, off, src, dst, fill);
        chk({name, "_busy"}, bus.busy, 1);
        wait_out(lat);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_result"}, bus.result, exp);
        ack();
    endtask

    initial begin
        logic [127:0] s_seq, dst_a, res_hold, exp_v;
        int lat, seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = SLIDE_UP;
        bus.sew       = '0;
        bus.offset    = '0;
        bus.src       = '0;
        bus.dst_old   = '0;
        bus.fill      = '0;

        s_seq = 128'h0f0e0d0c0b0a09080706050403020100;
        dst_a = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        tbl.push_back('{"up32_off1", 2'd0, 2'd2, 5'd1,
            128'h10000003_10000002_10000001_10000000, 128'hd0000003_d0000002_d0000001_d0000000,
            32'h0, 128'h10000002_10000001_10000000_d0000000, 4});
        tbl.push_back('{"down8_off2", 2'd1, 2'd0, 5'd2, s_seq, dst_a, 32'h0,
            128'h00000f0e0d0c0b0a0908070605040302, 16});
        tbl.push_back('{"s1down16", 2'd3, 2'd1, 5'd9, s_seq, dst_a, 32'habcd1234,
            128'h12340f0e0d0c0b0a0908070605040302, 8});
        tbl.push_back('{"s1up16", 2'd2, 2'd1, 5'd9, s_seq, dst_a, 32'habcd1234,
            128'h0d0c0b0a090807060504030201001234, 8});
        tbl.push_back('{"up8_off20", 2'd0, 2'd0, 5'd20, s_seq, dst_a, 32'h0, dst_a, 16});
        tbl.push_back('{"down8_off20", 2'd1, 2'd0, 5'd20, s_seq, dst_a, 32'h0, 128'h0, 16});
        tbl.push_back('{"down8_off16", 2'd1, 2'd0, 5'd16, s_seq, dst_a, 32'h0, 128'h0, 16});
        tbl.push_back('{"up_sew3_off4", 2'd0, 2'd3, 5'd4, s_seq, dst_a, 32'h0, dst_a, 4});
        tbl.push_back('{"down32_off0", 2'd1, 2'd2, 5'd0, s_seq, dst_a, 32'h0, s_seq, 4});
        tbl.push_back('{"s1up8", 2'd2, 2'd0, 5'd0, s_seq, dst_a, 32'hffffff5a,
            128'h0e0d0c0b0a090807060504030201005a, 16});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", bus.result, 0);

        foreach (tbl[k])
            run_one(tbl[k].name, tbl[k].op, tbl[k].sew, tbl[k].off, tbl[k].src,
                    tbl[k].dst, tbl[k].fill, tbl[k].exp, tbl[k].lat);

        for (int k = 0; k < 40; k++) begin
            logic [1:0] op, sew;
            logic [4:0] off;
            logic [127:0] src, dst;
            logic [31:0] fill;
            op   = 2'($urandom);
            sew  = 2'($urandom);
            off  = 5'($urandom_range(0, 31));
            src  = rnd128();
            dst  = rnd128();
            fill = $urandom;
            run_one("rand", op, sew, off, src, dst, fill, model(op, sew, off, src, dst, fill),
                    (sew == 0) ? 16 : (sew == 1) ? 8 : 4);
        end

        // Backpressure: result held in DONE, stray in_valid ignored.
        exp_v = 128'h10000002_10000001_10000000_d0000000;
        start_req(2'd0, 2'd2, 5'd1, 128'h10000003_10000002_10000001_10000000,
                  128'hd0000003_d0000002_d0000001_d0000000, 32'h0);
        wait_out(lat);
        chk("bp_lat", lat, 4);
        res_hold = bus.result;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c == 2);
            bus.op       = SLIDE_DOWN;
            @(posedge clk);
            #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_result", bus.result, exp_v);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        chk("bp_stable", bus.result, res_hold);
        ack();
        chk("bp_after_in_ready", bus.in_ready, 1);
        chk("bp_after_out_valid", bus.out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_ghost_busy", bus.busy, 0);

        // Reset during the third RUN cycle aborts the request.
        s_seq = rnd128();
        start_req(2'd0, 2'd0, 5'd0, s_seq, dst_a, 32'h0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_partial", bus.result, s_seq & 128'hffff);
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_result", bus.result, 0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen++;
        end
        chk("mrst_no_response", seen, 0);
        run_one("post_rst", 2'd1, 2'd1, 5'd3, s_seq, dst_a, 32'h0,
                model(1, 1, 3, s_seq, dst_a, 32'h0), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
